sum_window_accum: RTL and testbench
===================================

Name: sum_window_accum

Overview:
- Downstream consumer of the registered 8-bit adder sum stream.
- Accumulates a fixed window of 2^WIN_LOG2 accepted samples and presents the window total plus truncated average.
- Uses a valid/ready handshake on both sides.
- Its result feeds later datapath stages (wide adders, result registers).

Parameters:
- DATA_W, 8, width of each input sample (matches adder sum width).
- WIN_LOG2, 3, log2 of window length; window = 8 samples by default; legal range 1..8.
- ACC_W, DATA_W+WIN_LOG2, accumulator/total width; must not be overridden smaller.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort: discards the partial window and any held result.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  DATA_W  unsigned sample.
- in_ready  output  1  block can accept a sample this cycle.
- out_valid  output  1  out_sum/out_avg hold a completed window result.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  unsigned sum of the window's samples.
- out_avg  output  DATA_W  out_sum >> WIN_LOG2 (truncating).
- win_cnt  output  WIN_LOG2  samples accepted in the current window.

Behaviour:
- Reset (rst high, async): state=ACCUM, acc=0, win_cnt=0, out_valid=0, out_sum=0, out_avg=0. in_ready follows state, so it reads 1 once rst deasserts. No partial window survives reset mid-operation.
- States:
  - ACCUM: in_ready=1.
  - HOLD: in_ready=0, out_valid=1.
- Input transfer = in_valid & in_ready on a rising clk edge. in_data is ignored when there is no transfer.
- ACCUM, transfer with win_cnt < 2^WIN_LOG2-1: acc <= acc + in_data (zero-extended to ACC_W); win_cnt++.
- ACCUM, transfer with win_cnt == 2^WIN_LOG2-1 (last sample):
  - out_sum <= acc + in_data; out_avg <= (acc + in_data) >> WIN_LOG2.
  - acc <= 0; win_cnt <= 0 (wraps); state <= HOLD.
  - out_valid rises the cycle after the last sample is accepted (latency 1).
- HOLD:
  - out_sum/out_avg stay stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: state <= ACCUM, out_valid <= 0 next cycle. out_sum/out_avg keep their last values.
  - Minimum spacing between results = 2^WIN_LOG2 + 1 cycles (one bubble cycle for the HOLD handshake).
- Width: ACC_W bits hold the worst case 2^WIN_LOG2*(2^DATA_W-1) exactly; no overflow or saturation logic.
- clear (synchronous): highest priority below rst. Forces state=ACCUM, acc=0, win_cnt=0, out_valid=0. An input transfer in the same cycle is dropped. A held result is discarded even if out_ready=1 that cycle. out_sum/out_avg are not required to change.
- in_valid must not depend combinationally on in_ready. out_valid must not depend on out_ready. No combinational path from in_* to out_*.
- All outputs are registered except in_ready, which is decoded from the state register.

Test Plan:
- Reset then 8 back-to-back samples 10,20,...,80 with out_ready=1 -> out_valid high for exactly 1 cycle, 1 cycle after the 8th accept; out_sum=360, out_avg=45; win_cnt 0..7 then 0.
- 8 samples of 255, out_ready held 0 for 5 cycles -> out_sum=2040 (0x7F8), out_avg=255, stable for all 5 cycles; in_ready=0 throughout; after out_ready=1, in_ready=1 the next cycle.
- Samples 1,2,3 with in_valid gaps, then clear together with in_valid (sample 9), then 8 samples of 4 -> the sample 9 is dropped; out_sum=32, out_avg=4.
- Samples 1..7 (sum 28), rst pulsed asynchronously mid-cycle, then 8 samples of 1 -> out_valid=0 immediately on rst; result out_sum=8, out_avg=1.
- Samples 3,3,3,3,3,3,3,4 (sum 25) -> out_sum=25, out_avg=3 (truncation).
- Result held in HOLD with clear=1 and out_ready=1 in the same cycle -> out_valid=0 next cycle; no extra result appears; the next window counts from 0.

Source files
------------

// File: rtl/sum_window_accum.sv
// Accumulates a fixed window of 2^WIN_LOG2 accepted samples.
// Each window total and its truncated average are presented on a valid/ready output.
module sum_window_accum #(
    parameter int DATA_W   = 8,
    parameter int WIN_LOG2 = 3,
    parameter int ACC_W    = DATA_W + WIN_LOG2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clear,
    input  logic                i_in_valid,
    input  logic [DATA_W-1:0]   i_in_data,
    output logic                o_in_ready,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [ACC_W-1:0]    o_out_sum,
    output logic [DATA_W-1:0]   o_out_avg,
    output logic [WIN_LOG2-1:0] o_win_cnt
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    // A narrower accumulator would silently wrap on a full-scale window.
    if (ACC_W < DATA_W + WIN_LOG2) begin : g_acc_too_narrow
        $error("sum_window_accum: ACC_W must be at least DATA_W + WIN_LOG2");
    end

    logic [0:0]          r_state;
    logic [ACC_W-1:0]    r_acc;
    logic [WIN_LOG2-1:0] r_cnt;
    logic                r_out_valid;
    logic [ACC_W-1:0]    r_out_sum;
    logic [DATA_W-1:0]   r_out_avg;

    logic                w_last;
    logic [ACC_W-1:0]    w_next_sum;

    assign w_last     = (r_cnt == {WIN_LOG2{1'b1}});
    assign w_next_sum = r_acc + ACC_W'(i_in_data);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_avg   <= '0;
        end else if (i_clear) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (i_in_valid) begin
                        if (w_last) begin
                            r_out_sum   <= w_next_sum;
                            r_out_avg   <= DATA_W'(w_next_sum >> WIN_LOG2);
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_HOLD;
                        end else begin
                            r_acc <= w_next_sum;
                            r_cnt <= r_cnt + WIN_LOG2'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_ACCUM;
                    end
                end
                default: begin
                    r_state     <= ST_ACCUM;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = (r_state == ST_ACCUM);
    assign o_out_valid = r_out_valid;
    assign o_out_sum   = r_out_sum;
    assign o_out_avg   = r_out_avg;
    assign o_win_cnt   = r_cnt;

endmodule

// File: tb/tb_sum_window_accum.sv
// Directed self-checking bench for sum_window_accum with hand-computed window results.
// Inputs change 1 ns after a rising edge; outputs are checked at that same point.
module tb_sum_window_accum;

    localparam int DATA_W   = 8;
    localparam int WIN_LOG2 = 3;
    localparam int ACC_W    = DATA_W + WIN_LOG2;

    logic                clk;
    logic                rst;
    logic                clear;
    logic                inValid;
    logic [DATA_W-1:0]   inData;
    logic                inReady;
    logic                outValid;
    logic                outReady;
    logic [ACC_W-1:0]    outSum;
    logic [DATA_W-1:0]   outAvg;
    logic [WIN_LOG2-1:0] winCnt;

    int testsRun    = 0;
    int testsFailed = 0;

    sum_window_accum #(
        .DATA_W  (DATA_W),
        .WIN_LOG2(WIN_LOG2),
        .ACC_W   (ACC_W)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clear    (clear),
        .i_in_valid (inValid),
        .i_in_data  (inData),
        .o_in_ready (inReady),
        .o_out_valid(outValid),
        .i_out_ready(outReady),
        .o_out_sum  (outSum),
        .o_out_avg  (outAvg),
        .o_win_cnt  (winCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [DATA_W-1:0] data);
        inValid = valid;
        inData  = data;
        tick();
        inValid = 1'b0;
        inData  = '0;
    endtask

    // Streams a full window of one repeated value, checking the count before each accept.
    task automatic sendWindow(input string tag, input logic [DATA_W-1:0] data);
        for (int i = 0; i < 8; i++) begin
            checkOutput({tag, " cnt"}, 32'(winCnt), 32'(i));
            checkOutput({tag, " early valid"}, 32'(outValid), 32'd0);
            applyStimulus(1'b1, data);
        end
    endtask

    initial begin
        rst      = 1'b1;
        clear    = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        checkOutput("reset in_ready", 32'(inReady), 32'd1);
        checkOutput("reset out_valid", 32'(outValid), 32'd0);
        checkOutput("reset out_sum", 32'(outSum), 32'd0);
        checkOutput("reset out_avg", 32'(outAvg), 32'd0);
        checkOutput("reset win_cnt", 32'(winCnt), 32'd0);

        // Window 1: 10..80 back-to-back, consumer always ready.
        outReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput("w1 cnt", 32'(winCnt), 32'(i));
            checkOutput("w1 early valid", 32'(outValid), 32'd0);
            applyStimulus(1'b1, DATA_W'(10 * (i + 1)));
        end
        checkOutput("w1 out_valid", 32'(outValid), 32'd1);
        checkOutput("w1 out_sum", 32'(outSum), 32'd360);
        checkOutput("w1 out_avg", 32'(outAvg), 32'd45);
        checkOutput("w1 cnt wrap", 32'(winCnt), 32'd0);
        checkOutput("w1 in_ready hold", 32'(inReady), 32'd0);
        tick();
        checkOutput("w1 valid one cycle", 32'(outValid), 32'd0);
        checkOutput("w1 in_ready back", 32'(inReady), 32'd1);

        // Window 2: full-scale samples, result back-pressured for 5 cycles.
        outReady = 1'b0;
        sendWindow("w2", 8'd255);
        for (int i = 0; i < 5; i++) begin
            inValid = 1'b1;
            inData  = 8'd99;
            checkOutput("w2 hold valid", 32'(outValid), 32'd1);
            checkOutput("w2 hold sum", 32'(outSum), 32'd2040);
            checkOutput("w2 hold avg", 32'(outAvg), 32'd255);
            checkOutput("w2 hold in_ready", 32'(inReady), 32'd0);
            checkOutput("w2 hold cnt", 32'(winCnt), 32'd0);
            tick();
        end
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b1;
        tick();
        checkOutput("w2 released valid", 32'(outValid), 32'd0);
        checkOutput("w2 released in_ready", 32'(inReady), 32'd1);
        checkOutput("w2 sum retained", 32'(outSum), 32'd2040);
        checkOutput("w2 cnt after hold", 32'(winCnt), 32'd0);

        // Window 3: partial window with gaps, then clear drops a concurrent sample.
        applyStimulus(1'b1, 8'd1);
        applyStimulus(1'b0, 8'd50);
        applyStimulus(1'b1, 8'd2);
        applyStimulus(1'b0, 8'd60);
        applyStimulus(1'b1, 8'd3);
        checkOutput("w3 partial cnt", 32'(winCnt), 32'd3);
        clear = 1'b1;
        applyStimulus(1'b1, 8'd9);
        clear = 1'b0;
        checkOutput("w3 clear cnt", 32'(winCnt), 32'd0);
        checkOutput("w3 clear valid", 32'(outValid), 32'd0);
        sendWindow("w3", 8'd4);
        checkOutput("w3 out_valid", 32'(outValid), 32'd1);
        checkOutput("w3 out_sum", 32'(outSum), 32'd32);
        checkOutput("w3 out_avg", 32'(outAvg), 32'd4);
        tick();

        // Window 4: seven samples, async reset between edges, then a fresh window.
        for (int i = 1; i <= 7; i++) applyStimulus(1'b1, DATA_W'(i));
        checkOutput("w4 partial cnt", 32'(winCnt), 32'd7);
        #3 rst = 1'b1;
        #1;
        checkOutput("w4 async cnt", 32'(winCnt), 32'd0);
        checkOutput("w4 async valid", 32'(outValid), 32'd0);
        checkOutput("w4 async sum", 32'(outSum), 32'd0);
        #1 rst = 1'b0;
        tick();
        sendWindow("w4", 8'd1);
        checkOutput("w4 out_sum", 32'(outSum), 32'd8);
        checkOutput("w4 out_avg", 32'(outAvg), 32'd1);
        tick();

        // Async reset while a result is held must drop out_valid without a clock edge.
        outReady = 1'b0;
        sendWindow("w4b", 8'd6);
        checkOutput("w4b held valid", 32'(outValid), 32'd1);
        #3 rst = 1'b1;
        #1;
        checkOutput("w4b async valid", 32'(outValid), 32'd0);
        checkOutput("w4b async in_ready", 32'(inReady), 32'd1);
        #1 rst = 1'b0;
        outReady = 1'b1;
        tick();

        // Window 5: truncating average.
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'd3);
        applyStimulus(1'b1, 8'd4);
        checkOutput("w5 out_valid", 32'(outValid), 32'd1);
        checkOutput("w5 out_sum", 32'(outSum), 32'd25);
        checkOutput("w5 out_avg", 32'(outAvg), 32'd3);
        tick();

        // Window 6: held result discarded by clear even with out_ready high.
        outReady = 1'b0;
        sendWindow("w6", 8'd5);
        checkOutput("w6 held sum", 32'(outSum), 32'd40);
        tick();
        checkOutput("w6 still held", 32'(outValid), 32'd1);
        clear    = 1'b1;
        outReady = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("w6 clear valid", 32'(outValid), 32'd0);
        checkOutput("w6 clear in_ready", 32'(inReady), 32'd1);
        checkOutput("w6 clear cnt", 32'(winCnt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("w6 no extra result", 32'(outValid), 32'd0);
        end
        sendWindow("w7", 8'd2);
        checkOutput("w7 out_valid", 32'(outValid), 32'd1);
        checkOutput("w7 out_sum", 32'(outSum), 32'd16);
        checkOutput("w7 out_avg", 32'(outAvg), 32'd2);
        tick();
        checkOutput("w7 consumed", 32'(outValid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
